// File: rtl/regfile_writeback_pkg.sv
// Shared constants for the register-file write-back front end:
// load funct3 encodings and the hard-wired zero register index.
package regfile_writeback_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/regfile_writeback_load_extend.sv
// Selects the addressed byte/halfword of an aligned load word and
// sign- or zero-extends it; unknown load types pass the word through.
module load_extend
    import regfile_writeback_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_offset,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_data[{mem_offset, 3'b000} +: 8];
    assign half_sel = mem_data[{mem_offset[1], 4'b0000} +: 16];

    always_comb begin
        result = mem_data;
        case (mem_funct3)
            LB:      result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LH:      result = {{(XLEN-16){half_sel[15]}}, half_sel};
            LW:      result = mem_data;
            LBU:     result = {{(XLEN-8){1'b0}}, byte_sel};
            LHU:     result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = mem_data;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front end: arbitrates ALU/load results into an in-order FIFO that
// drains onto the register-file write port and forwards pending values to decode.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_dest,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_dest,
    input  logic [XLEN-1:0] mem_data,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_offset,
    input  logic            hold,
    output logic [4:0]      dest,
    output logic            write_enable,
    output logic [XLEN-1:0] data_in,
    input  logic [4:0]      src_one,
    input  logic [4:0]      src_two,
    output logic            busy_one,
    output logic            busy_two,
    output logic [XLEN-1:0] fwd_one,
    output logic [XLEN-1:0] fwd_two,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]      dest_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            mem_fire;
    logic            alu_fire;
    logic            push;
    logic            pop;
    logic [4:0]      enq_dest;
    logic [XLEN-1:0] enq_data;
    logic [XLEN-1:0] ext_data;
    logic [PW-1:0]   idx;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_data   (mem_data),
        .mem_funct3 (mem_funct3),
        .mem_offset (mem_offset),
        .result     (ext_data)
    );

    // Readies depend only on registered occupancy, so a drain this cycle never frees a slot early.
    assign full      = (count == FULL_COUNT);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    assign enq_dest = mem_fire ? mem_dest : alu_dest;
    assign enq_data = mem_fire ? ext_data : alu_data;
    assign push     = (mem_fire || alu_fire) && (enq_dest != X0);

    assign empty        = (count == '0);
    assign write_enable = !empty && !hold;
    assign pop          = write_enable;
    assign dest         = empty ? '0 : dest_q[rd_ptr];
    assign data_in      = empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                dest_q[wr_ptr] <= enq_dest;
                data_q[wr_ptr] <= enq_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last hit leaves the youngest matching value.
    always_comb begin
        busy_one = 1'b0;
        busy_two = 1'b0;
        fwd_one  = '0;
        fwd_two  = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if ((src_one != X0) && (dest_q[idx] == src_one)) begin
                    busy_one = 1'b1;
                    fwd_one  = data_q[idx];
                end
                if ((src_two != X0) && (dest_q[idx] == src_two)) begin
                    busy_two = 1'b1;
                    fwd_two  = data_q[idx];
                end
            end
        end
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 32-entry register file: accepts completed results from the ALU and the load path through valid/ready handshakes, sign- or zero-extends load data, and buffers results in a small in-order FIFO. The FIFO drains one entry per cycle onto the register file write port (`dest`, `write_enable`, `data_in`). It also reports pending writes and forwards the youngest pending value to the decode-stage read ports (`src_one`, `src_two`).

## Interface
Parameters:
- `XLEN`, 32, data width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `alu_valid` / `alu_ready`  in / out  1 / 1  ALU result handshake.
- `alu_dest`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid` / `mem_ready`  in / out  1 / 1  load result handshake.
- `mem_dest`  in  5  load destination register.
- `mem_data`  in  XLEN  aligned memory word.
- `mem_funct3`  in  3  load type.
- `mem_offset`  in  2  byte address bits [1:0].
- `hold`  in  1  register-file port blocked; suppresses drain.
- `dest`  out  5  register-file write address.
- `write_enable`  out  1  register-file write strobe.
- `data_in`  out  XLEN  register-file write data.
- `src_one`, `src_two`  in  5  decode read addresses.
- `busy_one`, `busy_two`  out  1  a pending FIFO entry targets the source.
- `fwd_one`, `fwd_two`  out  XLEN  data of the youngest matching pending entry (0 if none).
- `empty`  out  1  FIFO holds no entries.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge. Once valid is asserted, the producer holds valid and its payload until the transfer.
- Enqueue limit: at most one enqueue per cycle. `mem` has fixed priority.
  - `mem_ready = (count < DEPTH)`.
  - `alu_ready = (count < DEPTH) && !mem_valid`.
  - `count` is the registered occupancy. A same-cycle drain does not create a free slot.
- x0: a transfer with dest = 0 completes the handshake but is not enqueued.
- Load extension, `mem_funct3` (byte selected by `mem_offset`, halfword by `mem_offset[1]`):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
  - Any other code: treated as LW.
- Drain:
  - `write_enable = !empty && !hold`.
  - `dest` and `data_in` are driven from the head entry, or 0 when empty.
  - The head pops on every edge where `write_enable` is high. The register file always accepts the write.
- Order: writes retire strictly in acceptance order.
- Busy and forward:
  - A source matches a pending entry when the source is non-zero and equals that entry's dest.
  - Combinational over valid entries only. An incoming, not-yet-enqueued result does not count.
  - Forwarded data comes from the youngest matching entry.
- Simultaneous enqueue and drain: occupancy stays unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `write_enable`, `dest`, `data_in`: 0.
  - `busy_*`, `fwd_*`: 0.
  - `empty`: 1.
  - `alu_ready`, `mem_ready`: 1 (subject to `mem_valid`).
  - Pointers, count and storage: 0.
- Reset asserted mid-operation discards every pending entry; no write strobe follows.
- Latency: a result accepted at edge N is presented in cycle N+1 with `hold` = 0 and written at edge N+1.
- Throughput: one result per cycle sustained, without overflow.
- Full (count = DEPTH): both readies low. With `hold` = 1 and full, the block stalls indefinitely without loss.

## Structure
- Shared package holds:
  - Load funct3 constants: `LB`=000, `LH`=001, `LW`=010, `LBU`=100, `LHU`=101.
  - The x0 register index constant.
- Sub-module `load_extend`: combinational (`mem_data`, `mem_funct3`, `mem_offset`) → XLEN result.
- Top level holds the FIFO, arbitration and match/forward logic.

## Test plan
- Reset, then ALU transfer with dest=5, data 0xDEADBEEF → next cycle `write_enable`=1, `dest`=5, `data_in`=0xDEADBEEF, for exactly one cycle; `empty` returns to 1.
- `mem_data`=0x80017F80:
  - LB offset 0 → 0xFFFFFF80.
  - LBU offset 0 → 0x00000080.
  - LH offset 2 → 0xFFFF8001.
  - LHU offset 2 → 0x00008001.
  - funct3=111 → 0x80017F80.
- `alu_valid` and `mem_valid` in the same cycle → `alu_ready`=0; mem entry written first, ALU entry on the following cycle.
- `hold`=1, enqueue dest=7 data A then dest=7 data B:
  - `src_one`=7 → `busy_one`=1, `fwd_one`=B.
  - `src_two`=0 → `busy_two`=0.
  - Fill to DEPTH → both readies 0.
  - Release `hold` → four writes in order.
- ALU transfer with dest=0 → handshake completes; no write strobe; `empty` stays 1.
- Two entries pending with `hold`=1, then pulse `reset` low asynchronously between edges → outputs go to reset values immediately; no write after release.
